regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined core datapath, the successor to the single-write, two-read register file. It provides NUM_RD combinational read ports, two prioritised write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard with a pending-write counter. It sits between decode (reads, issue) and writeback (writes, busy clear).

---
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports,
// NUM_RD combinational read ports (optional same-cycle write bypass) and a
// per-register busy scoreboard with a registered popcount (busy_count).
// Write port 1 wins over port 0 on an address collision. An issue and a
// write to the same register in one cycle leave the register busy, because
// the issuing instruction is a newer producer.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd0,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [ADDR_W:0]            busy_count,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   count_q;

  // Effective write/issue strobes; everything is masked while rst is high so
  // that bypass is suppressed and nothing lands during reset.
  logic eff0, eff1, iss_eff, same_wa;
  assign eff0    = we0 && !rst && !(ZR && wa0 == '0);
  assign eff1    = we1 && !rst && !(ZR && wa1 == '0);
  assign iss_eff = iss_valid && !rst && !(ZR && iss_addr == '0);
  assign same_wa = eff0 && eff1 && (wa0 == wa1);

  // Incremental busy_count deltas. A clear only counts when the bit was set
  // and is not being re-set by a same-cycle issue; a doubled write to one
  // address counts once.
  logic inc, dec0, dec1;
  assign inc  = iss_eff && !busy[iss_addr];
  assign dec0 = eff0 && busy[wa0] && !(iss_eff && iss_addr == wa0);
  assign dec1 = eff1 && busy[wa1] && !(iss_eff && iss_addr == wa1) && !same_wa;

  // Register array: port 0 is skipped when port 1 hits the same address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (eff0 && !same_wa) mem[wa0] <= wd0;
      if (eff1)             mem[wa1] <= wd1;
    end
  end

  // Next scoreboard: write clears first, then issue sets (issue wins).
  always_comb begin
    busy_nxt = busy;
    if (eff0)    busy_nxt[wa0]      = 1'b0;
    if (eff1)    busy_nxt[wa1]      = 1'b0;
    if (iss_eff) busy_nxt[iss_addr] = 1'b1;
  end

  // Scoreboard bits and their running popcount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      count_q <= '0;
    end else begin
      busy    <= busy_nxt;
      count_q <= count_q + CW'(inc) - CW'(dec0) - CW'(dec1);
    end
  end

  assign busy_count = count_q;
  assign dbg_data   = (ZR && dbg_addr == '0) ? '0 : mem[dbg_addr];

  // Read ports: zero register, then bypass from port 1, then port 0, then
  // stored data. A bypassed register reports not-busy since its producer
  // is writing back right now.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit0, hit1, is_zero;
    assign a       = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = ZR && (a == '0);
    assign hit1    = BP && eff1 && (wa1 == a);
    assign hit0    = BP && eff0 && (wa0 == a);
    assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                         hit1    ? wd1 :
                                         hit0    ? wd0 : mem[a];
    assign rd_busy[k] = busy[a] && !hit0 && !hit1 && !is_zero;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two instances share one stimulus stream. dut_a has four
// read ports, bypass on and a hardwired zero register; dut_b has two read
// ports, no bypass and an ordinary register 0. Both are compared against a
// plain array model of the register file and busy set.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [4*AW-1:0] rd_addr;
  logic [4*DW-1:0] rd_data_a;
  logic [3:0]      rd_busy_a;
  logic [2*DW-1:0] rd_data_b;
  logic [1:0]      rd_busy_b;
  logic            we0, we1, iss_valid;
  logic [AW-1:0]   wa0, wa1, iss_addr, dbg_addr;
  logic [DW-1:0]   wd0, wd1, dbg_a, dbg_b;
  logic [AW:0]     cnt_a, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_count(cnt_a),
    .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr[2*AW-1:0]), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_count(cnt_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem  [2][DEPTH];
  bit            m_busy [2][DEPTH];

  function automatic bit zr(int d);
    return d == 0;
  endfunction

  function automatic bit byp(int d);
    return d == 0;
  endfunction

  function automatic bit eff(int d, logic we, logic [AW-1:0] wa);
    return !rst && we && !(zr(d) && wa == 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(int d, logic [AW-1:0] a);
    if (zr(d) && a == 0) return '0;
    if (byp(d) && eff(d, we1, wa1) && wa1 == a) return wd1;
    if (byp(d) && eff(d, we0, wa0) && wa0 == a) return wd0;
    return m_mem[d][a];
  endfunction

  function automatic bit exp_busy(int d, logic [AW-1:0] a);
    if (zr(d) && a == 0) return 1'b0;
    if (byp(d) && ((eff(d, we1, wa1) && wa1 == a) || (eff(d, we0, wa0) && wa0 == a))) return 1'b0;
    return m_busy[d][a];
  endfunction

  function automatic int exp_cnt(int d);
    int s = 0;
    for (int r = 0; r < DEPTH; r++) s += int'(m_busy[d][r]);
    return s;
  endfunction

  function automatic logic [DW-1:0] exp_dbg(int d);
    if (zr(d) && dbg_addr == 0) return '0;
    return m_mem[d][dbg_addr];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[d][r]  = '0;
        m_busy[d][r] = 1'b0;
      end
  endtask

  // Applies one rising edge to the model using the current inputs.
  task automatic model_clock();
    if (rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (eff(d, we0, wa0)) m_mem[d][wa0] = wd0;
        if (eff(d, we1, wa1)) m_mem[d][wa1] = wd1;
        if (eff(d, we0, wa0)) m_busy[d][wa0] = 1'b0;
        if (eff(d, we1, wa1)) m_busy[d][wa1] = 1'b0;
        if (iss_valid && !(zr(d) && iss_addr == 0)) m_busy[d][iss_addr] = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("model a rd_data%0d", k), rd_data_a[k*DW +: DW], exp_rd(0, rd_addr[k*AW +: AW]));
      check($sformatf("model a rd_busy%0d", k), DW'(rd_busy_a[k]), DW'(exp_busy(0, rd_addr[k*AW +: AW])));
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model b rd_data%0d", k), rd_data_b[k*DW +: DW], exp_rd(1, rd_addr[k*AW +: AW]));
      check($sformatf("model b rd_busy%0d", k), DW'(rd_busy_b[k]), DW'(exp_busy(1, rd_addr[k*AW +: AW])));
    end
    check("model a busy_count", DW'(cnt_a), DW'(exp_cnt(0)));
    check("model b busy_count", DW'(cnt_b), DW'(exp_cnt(1)));
    check("model a dbg_data", dbg_a, exp_dbg(0));
    check("model b dbg_data", dbg_b, exp_dbg(1));
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_in(bit w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                        bit w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                        bit iv, logic [AW-1:0] ia, logic [AW-1:0] ra);
    we0 = w0; wa0 = a0; wd0 = d0;
    we1 = w1; wa1 = a1; wd1 = d1;
    iss_valid = iv; iss_addr = ia;
    rd_addr = {4{ra}};
    dbg_addr = ra;
  endtask

  typedef struct {
    bit            w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    bit            w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    bit            iv;
    logic [AW-1:0] ia;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_a;
    bit            exp_busy_a;
    int            exp_cnt_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  function automatic vec_t mk(bit w0, int a0, logic [DW-1:0] d0, bit w1, int a1, logic [DW-1:0] d1,
                              bit iv, int ia, int ra, logic [DW-1:0] ea, bit eb, int ec, logic [DW-1:0] ebd);
    vec_t v;
    v.w0 = w0; v.a0 = AW'(a0); v.d0 = d0;
    v.w1 = w1; v.a1 = AW'(a1); v.d1 = d1;
    v.iv = iv; v.ia = AW'(ia); v.ra = AW'(ra);
    v.exp_a = ea; v.exp_busy_a = eb; v.exp_cnt_a = ec; v.exp_b = ebd;
    return v;
  endfunction

  vec_t vt[11];

  initial begin
    // Directed table: expected values for dut_a port 0 / dut_b port 0.
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0, 5, 32'hDEADBEEF, 0, 0, 32'h0);
    vt[1]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 5, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
    vt[2]  = mk(1, 7, 32'h11,       1, 7, 32'h22, 0, 0, 7, 32'h22,      0, 0, 32'h0);
    vt[3]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 7, 32'h22,       0, 0, 32'h22);
    vt[4]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,     1, 0, 0, 32'h0,        0, 0, 32'h0);
    vt[5]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 32'h0,        0, 0, 32'hFFFFFFFF);
    vt[6]  = mk(0, 0, 0,            0, 0, 0,     1, 3, 3, 32'h0,        0, 0, 32'h0);
    vt[7]  = mk(0, 0, 0,            0, 0, 0,     1, 4, 3, 32'h0,        1, 1, 32'h0);
    vt[8]  = mk(1, 3, 32'h33,       0, 0, 0,     1, 3, 3, 32'h33,       0, 2, 32'h0);
    vt[9]  = mk(1, 3, 32'h44,       1, 4, 32'h55, 0, 0, 3, 32'h44,      0, 2, 32'h33);
    vt[10] = mk(0, 0, 0,            0, 0, 0,     0, 0, 4, 32'h55,       0, 0, 32'h55);

    // Reset phase, with a write enable held high: bypass must stay quiet.
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    set_in(1, 5, 32'hDEADBEEF, 1, 6, 32'h66, 1, 5, 5);
    #1;
    check("reset rd_data", rd_data_a[DW-1:0], 32'h0);
    check("reset rd_busy", DW'(rd_busy_a), 32'h0);
    check("reset busy_count", DW'(cnt_a), 32'h0);
    check("reset dbg_data", dbg_a, 32'h0);
    check_model();
    tick();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 5);
    #1;
    check("post-reset write discarded", rd_data_b[DW-1:0], 32'h0);
    check_model();
    tick();

    // Table-driven directed vectors.
    for (int i = 0; i < 11; i++) begin
      set_in(vt[i].w0, vt[i].a0, vt[i].d0, vt[i].w1, vt[i].a1, vt[i].d1, vt[i].iv, vt[i].ia, vt[i].ra);
      #1;
      check($sformatf("vec%0d a rd_data", i), rd_data_a[DW-1:0], vt[i].exp_a);
      check($sformatf("vec%0d a rd_busy", i), DW'(rd_busy_a[0]), DW'(vt[i].exp_busy_a));
      check($sformatf("vec%0d a busy_count", i), DW'(cnt_a), DW'(vt[i].exp_cnt_a));
      check($sformatf("vec%0d b rd_data", i), rd_data_b[DW-1:0], vt[i].exp_b);
      check_model();
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 7);
    #1;
    check("dual write dbg r7", dbg_a, 32'h22);

    // Four distinct read addresses, two writes hitting ports 1 and 3.
    set_in(1, 10, 32'hA0, 1, 12, 32'hC0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 11, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 13, 0); tick();
    set_in(1, 13, 32'hD3, 1, 11, 32'hB1, 0, 0, 0);
    rd_addr = {5'd13, 5'd12, 5'd11, 5'd10};
    #1;
    check("4port rd0", rd_data_a[0*DW +: DW], 32'hA0);
    check("4port rd1", rd_data_a[1*DW +: DW], 32'hB1);
    check("4port rd2", rd_data_a[2*DW +: DW], 32'hC0);
    check("4port rd3", rd_data_a[3*DW +: DW], 32'hD3);
    check("4port busy", DW'(rd_busy_a), 32'h0);
    check_model();
    tick();

    // Issue every nonzero register; count saturates at DEPTH-1 for dut_a.
    for (int r = 1; r < DEPTH; r++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, AW'(r), AW'(r));
      #1;
      check_model();
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
    #1;
    check("issue-all count", DW'(cnt_a), 32'd31);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("reissue no wrap", DW'(cnt_a), 32'd31);
    check_model();

    // Randomized traffic on a narrow address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = AW'($urandom_range(0, 7));
      wa1 = AW'($urandom_range(0, 7));
      wd0 = $urandom;
      wd1 = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = AW'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 8));
      dbg_addr = AW'($urandom_range(0, 8));
      #1;
      check_model();
      tick();
    end

    // Clean reset, then r9 = 0x1234 and three busy registers.
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    set_in(1, 9, 32'h1234, 0, 0, 0, 1, 1, 9); tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 2, 9); tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 6, 9); tick();
    set_in(1, 9, 32'h5678, 0, 0, 0, 0, 0, 9);
    #1;
    check("pre-async count", DW'(cnt_a), 32'd3);
    check("pre-async bypass r9", rd_data_a[DW-1:0], 32'h5678);
    check_model();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async rd_data r9", rd_data_a[DW-1:0], 32'h0);
    check("async busy_count", DW'(cnt_a), 32'h0);
    check("async dbg r9", dbg_b, 32'h0);
    check_model();
    tick();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 9);
    #1;
    check("held write dropped a", rd_data_a[DW-1:0], 32'h0);
    check("held write dropped b", rd_data_b[DW-1:0], 32'h0);
    check_model();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
